// File: rtl/fan_alu_sequencer.sv
// fan_alu_sequencer: drives SUB then MUL on an external alu and turns the product into a fan duty value
// Optional duty slew limiting is enabled by defining FAN_SLEW_EN.
module fan_alu_sequencer #(
    parameter int ALU_SETTLE = 1,
    parameter int GAIN_SHIFT = 4,
    parameter int MIN_DUTY   = 0,
    parameter int MAX_STEP   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        temp_valid,
    output logic        temp_ready,
    input  logic [7:0]  temp_in,
    input  logic [7:0]  threshold,
    input  logic [7:0]  gain,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    input  logic [15:0] alu_result,
    input  logic        alu_flagC,
    input  logic        alu_flagZ,
    output logic        duty_valid,
    input  logic        duty_ready,
    output logic [7:0]  duty_out,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SUB_WAIT, MUL_WAIT, CALC, OUT} state_t;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam int CW = ALU_SETTLE > 1 ? $clog2(ALU_SETTLE) : 1;
`ifdef FAN_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [7:0] gain_q, last_duty, clamp, target, duty_next;
    logic [15:0] product, scaled;
    logic settled, skip;
    int diff, step;
    assign settled = cnt == CW'(ALU_SETTLE - 1);
    // temp <= threshold shows up as a borrow or a zero difference
    assign skip = !alu_flagC || alu_flagZ;
    // next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        temp_ready = 1'b0;
        duty_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                temp_ready = 1'b1;
                busy       = 1'b0;
                if (temp_valid) state_next = SUB_WAIT;
            end
            SUB_WAIT: if (settled) state_next = skip ? CALC : MUL_WAIT;
            MUL_WAIT: if (settled) state_next = CALC;
            CALC:     state_next = OUT;
            OUT: begin
                duty_valid = 1'b1;
                if (duty_ready) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end
    // settle counter restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n || state_next != state) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
    // scale, clamp to 8 bits, floor at MIN_DUTY, then optionally slew-limit
    always_comb begin
        scaled    = product >> GAIN_SHIFT;
        clamp     = |scaled[15:8] ? 8'hFF : scaled[7:0];
        target    = int'(clamp) < MIN_DUTY ? 8'(MIN_DUTY) : clamp;
        diff      = int'(target) - int'(last_duty);
        step      = diff > MAX_STEP ? MAX_STEP : (diff < -MAX_STEP ? -MAX_STEP : diff);
        duty_next = SLEW ? 8'(int'(last_duty) + step) : target;
    end
    // alu operand issue, result capture and duty register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_opcode <= 3'b000;
            alu_op1    <= '0;
            alu_op2    <= '0;
            gain_q     <= '0;
            product    <= '0;
            duty_out   <= '0;
            last_duty  <= '0;
        end else begin
            case (state)
                IDLE: if (temp_valid) begin
                    alu_opcode <= OP_SUB;
                    alu_op1    <= temp_in;
                    alu_op2    <= threshold;
                    gain_q     <= gain;
                end
                SUB_WAIT: if (settled) begin
                    product <= '0;
                    if (!skip) begin
                        alu_opcode <= OP_MUL;
                        alu_op1    <= alu_result[7:0];
                        alu_op2    <= gain_q;
                    end
                end
                MUL_WAIT: if (settled) product <= alu_result;
                CALC: begin
                    duty_out  <= duty_next;
                    last_duty <= duty_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fan_alu_sequencer.sv
// tb_fan_alu_sequencer: random and directed checks of fan_alu_sequencer against a behavioural duty model
module tb_fan_alu_sequencer;
    localparam int S = 1, SHIFT = 4, MIN_D = 0, STEP = 16;
    logic clk = 0, rst_n = 0, temp_valid = 0, duty_ready = 1;
    logic [7:0] temp_in = 0, threshold = 0, gain = 0;
    logic temp_ready, duty_valid, busy, alu_flagC, alu_flagZ;
    logic [2:0] alu_opcode;
    logic [7:0] alu_op1, alu_op2, duty_out;
    logic [15:0] alu_result;
    int n_checks = 0, n_fail = 0, model_last = 0;

    always #5 clk = ~clk;

    fan_alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .temp_valid(temp_valid), .temp_ready(temp_ready),
        .temp_in(temp_in), .threshold(threshold), .gain(gain),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_flagC(alu_flagC), .alu_flagZ(alu_flagZ),
        .duty_valid(duty_valid), .duty_ready(duty_ready), .duty_out(duty_out), .busy(busy)
    );

    // external combinational alu
    always_comb begin
        alu_result = '0;
        alu_flagC  = 1'b0;
        alu_flagZ  = 1'b0;
        if (alu_opcode == 3'b001) begin
            alu_result = {8'd0, alu_op1 - alu_op2};
            alu_flagC  = alu_op1 >= alu_op2;
            alu_flagZ  = alu_op1 == alu_op2;
        end else if (alu_opcode == 3'b010) begin
            alu_result = alu_op1 * alu_op2;
            alu_flagZ  = alu_op1 == 0 || alu_op2 == 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_target(input int t, input int th, input int g);
        int s;
        if (t <= th) return MIN_D;
        s = ((t - th) * g) / (1 << SHIFT);
        if (s > 255) s = 255;
        if (s < MIN_D) s = MIN_D;
        return s;
    endfunction

    function automatic int ref_duty(input int tgt, input int last);
        int d;
        d = tgt;
`ifdef FAN_SLEW_EN
        if (tgt > last + STEP) d = last + STEP;
        if (tgt < last - STEP) d = last - STEP;
`endif
        return d;
    endfunction

    // one sample through the sequencer; call at #1 after an edge with the DUT idle
    task automatic run(input int t, input int th, input int g, input int hold);
        int lat, exp_d;
        bit mul;
        logic [7:0] held;
        mul = t > th;
        exp_d = ref_duty(ref_target(t, th, g), model_last);
        model_last = exp_d;
        check("ready_idle", temp_ready, 1);
        temp_valid = 1; temp_in = 8'(t); threshold = 8'(th); gain = 8'(g);
        @(posedge clk); #1;
        temp_valid = 0;
        check("sub_opcode", alu_opcode, 3'b001);
        check("sub_op1", alu_op1, t);
        check("sub_op2", alu_op2, th);
        check("busy", busy, 1);
        lat = 0;
        while (!duty_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (mul && lat == S) begin
                check("mul_opcode", alu_opcode, 3'b010);
                check("mul_op1", alu_op1, t - th);
                check("mul_op2", alu_op2, g);
            end
            if (!mul) check("no_mul", alu_opcode == 3'b010, 0);
        end
        check("latency", lat, mul ? 2 * S + 1 : S + 1);
        check("duty", duty_out, exp_d);
        check("ready_out", temp_ready, 0);
        if (hold > 0) begin
            duty_ready = 0;
            held = duty_out;
            repeat (hold) begin
                temp_valid = 1;
                temp_in = 8'($urandom);
                @(posedge clk); #1;
                check("hold_valid", duty_valid, 1);
                check("hold_duty", duty_out, held);
                check("hold_ready", temp_ready, 0);
            end
            duty_ready = 1;
        end
        @(posedge clk); #1;
        temp_valid = 0;
        check("valid_drop", duty_valid, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        check("rst_opcode", alu_opcode, 0);
        check("rst_duty", duty_out, 0);
        check("rst_valid", duty_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("rst_ready", temp_ready, 1);
        run(100, 60, 32, 0);
        run(100, 60, 32, 0);
        run(50, 60, 7, 0);
        run(60, 60, 9, 0);
        run(255, 0, 255, 0);
        run(200, 100, 3, 5);
        // abort during MUL_WAIT
        temp_valid = 1; temp_in = 150; threshold = 20; gain = 40;
        @(posedge clk); #1;
        temp_valid = 0;
        @(posedge clk); #1;
        check("mid_mul", alu_opcode, 3'b010);
        rst_n = 0;
        @(posedge clk); #1;
        check("abort_opcode", alu_opcode, 0);
        check("abort_op1", alu_op1, 0);
        check("abort_op2", alu_op2, 0);
        check("abort_duty", duty_out, 0);
        check("abort_valid", duty_valid, 0);
        check("abort_busy", busy, 0);
        rst_n = 1;
        model_last = 0;
        @(posedge clk); #1;
        check("abort_ready", temp_ready, 1);
        check("abort_novalid", duty_valid, 0);
        for (int i = 0; i < 40; i++)
            run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
